// File: rtl/cci_test_csr_bank.sv
// cci_test_csr_bank
//   MMIO CSR bank for MPF test AFUs. Decodes CCI-P MMIO requests against a
//   window of test CSRs followed by event counters. Local read responses are
//   queued and merged with AFU pass-through responses, which always win the
//   output slot.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mmio_req_*                 incoming MMIO request (addr in 4-byte units)
//   csr_rd_data                read values of the test CSRs (64 bits each)
//   ctr_inc                    per-counter increment this cycle (3 bits each)
//   afu_rsp_*                  pass-through read response from the AFU
//   csr_wr_en/mask/data        one-cycle write strobe to the test CSRs
//   rsp_*                      merged MMIO read response toward the FIU
//   err_rsp_overflow           sticky: a local read response was dropped
module cci_test_csr_bank #(
  parameter int NUM_TEST_CSRS  = 16,
  parameter int CSR_BASE       = 32,
  parameter int NUM_EVENT_CTRS = 8,
  parameter int CTR_WIDTH      = 48,
  parameter int CTR_SATURATE   = 0,
  parameter int RSP_FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mmio_req_valid,
  input  logic                        mmio_req_is_read,
  input  logic [15:0]                 mmio_req_addr,
  input  logic                        mmio_req_len64,
  input  logic [8:0]                  mmio_req_tid,
  input  logic [63:0]                 mmio_req_data,
  input  logic [NUM_TEST_CSRS*64-1:0] csr_rd_data,
  input  logic [NUM_EVENT_CTRS*3-1:0] ctr_inc,
  input  logic                        afu_rsp_valid,
  input  logic [8:0]                  afu_rsp_tid,
  input  logic [63:0]                 afu_rsp_data,
  output logic [NUM_TEST_CSRS-1:0]    csr_wr_en,
  output logic [1:0]                  csr_wr_mask,
  output logic [63:0]                 csr_wr_data,
  output logic                        rsp_valid,
  output logic [8:0]                  rsp_tid,
  output logic [63:0]                 rsp_data,
  output logic                        err_rsp_overflow
);

  localparam int NT     = NUM_TEST_CSRS;
  localparam int NE     = NUM_EVENT_CTRS;
  localparam int IDX_W  = 7;
  localparam int PTR_W  = $clog2(RSP_FIFO_DEPTH);
  localparam int CW     = PTR_W + 1;
  localparam int SW     = CTR_WIDTH + 4;
  localparam int ENT_W  = 9 + 64;
  localparam logic [15:0] WIN_LO = 16'(CSR_BASE);
  localparam logic [15:0] WIN_HI = 16'(CSR_BASE + NT + NE);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  // Add an increment to a counter, clamping or wrapping on overflow.
  function automatic logic [CTR_WIDTH-1:0] ctr_add(input logic [CTR_WIDTH-1:0] cur,
                                                   input logic [2:0] inc);
    logic [SW-1:0] sum;
    sum = SW'(cur) + SW'(inc);
    if (sum[SW-1:CTR_WIDTH] != '0)
      return (CTR_SATURATE != 0) ? CTR_MAX : sum[CTR_WIDTH-1:0];
    return sum[CTR_WIDTH-1:0];
  endfunction

  // ---- stage p0: request decode ----
  logic [14:0]      req_word;
  logic [15:0]      req_off_full;
  logic [IDX_W-1:0] req_idx;
  logic             req_hit, req_is_csr;
  logic             unused_off_bits;

  assign req_word        = mmio_req_addr[15:1];
  assign req_off_full    = {1'b0, req_word} - WIN_LO;
  assign req_idx         = req_off_full[IDX_W-1:0];
  assign unused_off_bits = ^req_off_full[15:IDX_W];
  assign req_hit         = mmio_req_valid && ({1'b0, req_word} >= WIN_LO) &&
                           ({1'b0, req_word} < WIN_HI);
  assign req_is_csr      = req_idx < IDX_W'(NT);

  logic [NT-1:0] wr_en_d, wr_en_q;
  logic [1:0]    wr_mask_d, wr_mask_q;
  logic [63:0]   wr_data_d, wr_data_q;

  always_comb begin
    wr_en_d   = '0;
    wr_mask_d = 2'b00;
    wr_data_d = wr_data_q;
    if (req_hit && !mmio_req_is_read && req_is_csr) begin
      for (int i = 0; i < NT; i++)
        if (req_idx == IDX_W'(i)) wr_en_d[i] = 1'b1;
      if (mmio_req_len64) begin
        wr_mask_d = 2'b11;
        wr_data_d = mmio_req_data;
      end else begin
        wr_mask_d = mmio_req_addr[0] ? 2'b10 : 2'b01;
        wr_data_d = {mmio_req_data[31:0], mmio_req_data[31:0]};
      end
    end
  end

  logic             rd_vld_p1_q, clr_vld_p1_q, len64_p1_q, hi_p1_q;
  logic [IDX_W-1:0] idx_p1_q;
  logic [8:0]       tid_p1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p1_q  <= 1'b0;
      clr_vld_p1_q <= 1'b0;
      idx_p1_q     <= '0;
      tid_p1_q     <= '0;
      len64_p1_q   <= 1'b0;
      hi_p1_q      <= 1'b0;
      wr_en_q      <= '0;
      wr_mask_q    <= 2'b00;
      wr_data_q    <= '0;
    end else begin
      rd_vld_p1_q  <= req_hit && mmio_req_is_read;
      clr_vld_p1_q <= req_hit && !mmio_req_is_read && !req_is_csr;
      idx_p1_q     <= req_idx;
      tid_p1_q     <= mmio_req_tid;
      len64_p1_q   <= mmio_req_len64;
      hi_p1_q      <= mmio_req_addr[0];
      wr_en_q      <= wr_en_d;
      wr_mask_q    <= wr_mask_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // ---- stage p1: read data select, counter update, response enqueue ----
  logic [CTR_WIDTH-1:0] ctr_q [NE];
  logic [63:0]          rd_word, rd_data;
  logic [31:0]          rd_dword;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NT; i++)
      if (idx_p1_q == IDX_W'(i)) rd_word = csr_rd_data[i*64 +: 64];
    for (int i = 0; i < NE; i++)
      if (idx_p1_q == IDX_W'(NT + i)) rd_word = 64'(ctr_q[i]);
    rd_dword = hi_p1_q ? rd_word[63:32] : rd_word[31:0];
    rd_data  = len64_p1_q ? rd_word : {rd_dword, rd_dword};
  end

  // A clear in the same cycle as an increment wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      if (reset)
        ctr_q[i] <= '0;
      else if (clr_vld_p1_q && idx_p1_q == IDX_W'(NT + i))
        ctr_q[i] <= '0;
      else
        ctr_q[i] <= ctr_add(ctr_q[i], ctr_inc[i*3 +: 3]);
    end
  end

  logic [ENT_W-1:0] fifo_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             fifo_empty, fifo_full, pop, push, drop;
  logic [ENT_W-1:0] fifo_head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(RSP_FIFO_DEPTH));
  // AFU responses own the output slot; the queue drains only in free cycles.
  assign pop        = !afu_rsp_valid && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign push       = rd_vld_p1_q && (!fifo_full || pop);
  assign drop       = rd_vld_p1_q && fifo_full && !pop;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {tid_p1_q, rd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // ---- stage p2: merged response output ----
  logic        rsp_valid_q, err_q;
  logic [8:0]  rsp_tid_q;
  logic [63:0] rsp_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= afu_rsp_valid || pop;
      if (afu_rsp_valid) begin
        rsp_tid_q  <= afu_rsp_tid;
        rsp_data_q <= afu_rsp_data;
      end else if (pop) begin
        rsp_tid_q  <= fifo_head[ENT_W-1:64];
        rsp_data_q <= fifo_head[63:0];
      end
      if (drop) err_q <= 1'b1;
    end
  end

  assign csr_wr_en        = wr_en_q;
  assign csr_wr_mask      = wr_mask_q;
  assign csr_wr_data      = wr_data_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_tid          = rsp_tid_q;
  assign rsp_data         = rsp_data_q;
  assign err_rsp_overflow = err_q;

endmodule
